// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain controller for the asynchronous FIFO. Lives entirely in the
// read clock domain. It turns the FIFO read port (rd_en / rd_empty / registered
// rd_data with one cycle of latency) into a valid/ready stream. A 4-entry
// prefetch buffer lets it sustain one word per clock under back-pressure.
// The stream is framed into fixed-length bursts with a last flag, and the
// words accepted downstream are counted.
//
// Parameters
//   WIDTH      data width, must match the FIFO
//   BURST_LEN  words per burst (>= 1)
//   CNT_W      width of the delivered-word counter
//
// Ports
//   rdclk          in   read-domain clock, rising edge
//   rd_rst_n       in   asynchronous active-low reset
//   en             in   permits new FIFO reads; buffered words drain regardless
//   fifo_rd_empty  in   FIFO empty flag
//   fifo_rd_en     out  FIFO read strobe
//   fifo_rd_data   in   FIFO read data, valid the cycle after a read
//   m_valid        out  output word available
//   m_ready        in   downstream accepts the word
//   m_data         out  output word
//   m_last         out  final word of the current burst
//   word_cnt       out  words accepted downstream, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic             rdclk,
  input  logic             rd_rst_n,
  input  logic             en,
  input  logic             fifo_rd_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int DEPTH  = 4;
  // A single-word burst still needs a one-bit beat register.
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  r_buf [DEPTH];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_occ;
  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0]  r_word_cnt;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [2:0]        w_outstanding;
  logic              w_has_space;
  logic              w_rd_en;
  logic              w_valid;
  logic              w_pop;
  logic              w_capture;
  logic              w_beat_last;
  logic [DEPTH-1:0]  w_buf_we;

  logic [1:0]        w_wr_ptr_next;
  logic [1:0]        w_rd_ptr_next;
  logic [2:0]        w_occ_next;
  logic [BEAT_W-1:0] w_beat_next;
  logic [CNT_W-1:0]  w_word_cnt_next;

  // Words already buffered plus the one still coming back from the FIFO.
  // Reserving a slot for the inflight word is what makes capture
  // unconditional. Never exceeds 4, so three bits are enough.
  assign w_outstanding = r_occ + {2'b00, r_inflight};
  assign w_has_space   = (w_outstanding < 3'd4);

  // Read issue depends only on registered state and FIFO/enable inputs, so
  // there is no combinational path from m_ready to the FIFO strobe.
  assign w_rd_en   = en & ~fifo_rd_empty & w_has_space;

  assign w_valid   = (r_occ != 3'd0);
  assign w_pop     = w_valid & m_ready;
  assign w_capture = r_inflight;

  assign w_beat_last = (r_beat == BEAT_MAX);

  // Per-entry write enables for the prefetch buffer.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_buf_we
      assign w_buf_we[gi] = w_capture & (r_wr_ptr == 2'(gi));
    end
  endgenerate

  always_comb begin
    w_wr_ptr_next   = r_wr_ptr;
    w_rd_ptr_next   = r_rd_ptr;
    w_occ_next      = r_occ;
    w_beat_next     = r_beat;
    w_word_cnt_next = r_word_cnt;

    // Two-bit pointers wrap 3 -> 0 naturally.
    if (w_capture) begin
      w_wr_ptr_next = r_wr_ptr + 2'd1;
    end

    if (w_pop) begin
      w_rd_ptr_next   = r_rd_ptr + 2'd1;
      w_word_cnt_next = r_word_cnt + CNT_W'(1);
      if (w_beat_last) begin
        w_beat_next = '0;
      end else begin
        w_beat_next = r_beat + BEAT_W'(1);
      end
    end

    // Capture and pop in the same cycle leave occupancy unchanged.
    case ({w_capture, w_pop})
      2'b10:   w_occ_next = r_occ + 3'd1;
      2'b01:   w_occ_next = r_occ - 3'd1;
      default: w_occ_next = r_occ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rdclk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_occ      <= 3'd0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_occ      <= w_occ_next;
      // A read issued this cycle returns data next cycle.
      r_inflight <= w_rd_en;
      r_beat     <= w_beat_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch buffer storage. Contents are meaningless after reset because
  // occupancy is cleared, so the array carries no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge rdclk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_buf_we[i]) begin
        r_buf[i] <= fifo_rd_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. m_data and m_last depend only on registers, so they hold while
  // the downstream stalls.
  // ---------------------------------------------------------------------------
  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_valid;
  assign m_data     = r_buf[r_rd_ptr];
  assign m_last     = w_valid & w_beat_last;
  assign word_cnt   = r_word_cnt;

endmodule
